mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
//
// PURPOSE
// - Shares the single data port of the unified memory (word-addressed, synchronous read,
//   1-cycle read latency, write on wen) between two requesters.
// - M0 = CPU load/store unit. M1 = program loader / debug DMA.
// - Sits between the requesters and the memory data port.
// - Sequences every access as grant -> issue -> response.
// - Guarantees one outstanding access, in-order responses and bounded M1 starvation.
//
// PARAMETERS
// - STARVE_LIMIT   4   consecutive M0 grants while M1 is waiting before M1 is forced; legal range >=1
// - CNT_W          3   starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT
//
// PORTS
// - clk          in   1          single clock, rising edge
// - rst          in   1          asynchronous, active-high reset
// - m0_req       in   1          M0 access request; held until m0_gnt
// - m0_we        in   1          M0 write (1) / read (0)
// - m0_addr      in   WORD_LEN   M0 byte address; [1:0] ignored
// - m0_wdata     in   WORD_LEN   M0 write data
// - m0_gnt       out  1          M0 request accepted this cycle (combinational)
// - m0_rvalid    out  1          M0 read data valid this cycle
// - m0_rdata     out  WORD_LEN   M0 read data
// - m1_*         --   --         identical set for M1: m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata
// - mem_addr     out  WORD_LEN   memory data-port address (registered)
// - mem_wen      out  1          memory write enable (registered)
// - mem_wdata    out  WORD_LEN   memory write data (registered)
// - mem_rdata    in   WORD_LEN   memory read data
//
// BEHAVIOUR
// - FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
// - IDLE:
//   - When any req is high, exactly one gnt is asserted in the same cycle.
//   - The winner's addr/we/wdata are registered onto mem_* at the next edge.
//   - Next state is ISSUE. gnt is asserted only in IDLE.
// - ISSUE:
//   - mem_* hold the winner's command; the memory samples it at the end of this cycle.
//   - mem_wen = winner's we.
//   - Next state is RESP for a read, IDLE for a write.
//   - A write commits at the end of ISSUE and produces no rvalid.
// - RESP:
//   - rvalid of the winner is high for exactly 1 cycle.
//   - rdata = mem_rdata, passed through; next state is IDLE.
// - Latency, gnt in cycle C:
//   - read: rvalid in cycle C+2; next gnt no earlier than C+3.
//   - write: next gnt no earlier than C+2.
// - mem_wen is 0 in every state except ISSUE with we=1.
// - mem_addr and mem_wdata hold their last value when unused.
// - Unselected mX_rdata = 0.
// - Arbitration (default):
//   - M0 has priority.
//   - starve_cnt increments on each M0 grant while m1_req=1.
//   - When starve_cnt == STARVE_LIMIT and m1_req=1, M1 wins even if m0_req=1.
//   - starve_cnt clears on an M1 grant or whenever m1_req=0 in IDLE.
//   - starve_cnt saturates; it never wraps.
// - Simultaneous requests are resolved by the rule above. A request arriving in ISSUE or RESP waits for IDLE.
// - A requester may drop req before gnt; nothing is issued for it.
// - Reset values: state=IDLE; gnt, rvalid, mem_wen = 0; mem_addr, mem_wdata, starve_cnt = 0; last-grant pointer = M1.
// - Reset asserted mid-access:
//   - takes effect immediately, asynchronously.
//   - mem_wen drops, so no partial write.
//   - a pending read response is discarded; there is no rvalid after reset.
//
// CONFIGURATION
// - MEM_ARB_RR_EN defined:
//   - strict round-robin; a 1-bit last-grant pointer picks the non-last requester on contention.
//   - a lone requester always wins.
//   - STARVE_LIMIT and starve_cnt are unused; the counter is removed.
// - MEM_ARB_RR_EN undefined: M0-priority with the starvation limit described above.
//
// TESTING
// - Read, M0 alone:
//   - Stimulus: m0_req, we=0, addr=0x10, memory word[4]=0xDEADBEEF.
//   - Required: m0_gnt in C; mem_addr=0x10, mem_wen=0 in C+1; m0_rvalid with 0xDEADBEEF in C+2.
// - Write, then read back:
//   - Stimulus: M1 writes 0x12345678 to 0x20, then reads 0x20.
//   - Required: mem_wen=1 for exactly 1 cycle; read returns 0x12345678; m1_rvalid pulses once.
// - Starvation, default build:
//   - Stimulus: m0_req and m1_req held high continuously with writes.
//   - Required: grant order M0,M0,M0,M0,M1, repeating.
// - Round-robin, MEM_ARB_RR_EN defined:
//   - Stimulus: same as the starvation test.
//   - Required: first grant to M0, then alternating M0,M1,M0,M1.
// - Reset mid-access:
//   - Stimulus: rst asserted during ISSUE of a write to 0x30 (old value 0xA5A5A5A5).
//   - Required: mem_wen=0 immediately; word stays 0xA5A5A5A5; no rvalid; state IDLE.
// - Request withdrawn:
//   - Stimulus: m1_req pulses for 1 cycle during RESP of an M0 read.
//   - Required: no m1_gnt; no memory access for M1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, grant/response and memory data-port signals of the two-master memory arbiter
interface mem_arbiter_if #(parameter int WORD_LEN = 32);
  logic                m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [WORD_LEN-1:0] m0_addr, m0_wdata, m0_rdata;
  logic                m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [WORD_LEN-1:0] m1_addr, m1_wdata, m1_rdata;
  logic                mem_wen;
  logic [WORD_LEN-1:0] mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, mem_wen, mem_addr, mem_wdata
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory data port between M0 (CPU) and M1 (loader/DMA), one access at a time.
// MEM_ARB_RR_EN selects round-robin; otherwise M0 priority with an M1 starvation limit.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic       sel;
  logic       any_req, pick1;
  assign any_req = bus.m0_req | bus.m1_req;
`ifdef MEM_ARB_RR_EN
  // sel still holds the previous winner while in IDLE, so it doubles as the last-grant pointer
  assign pick1 = bus.m1_req & (~bus.m0_req | ~sel);
`else
  logic [CNT_W-1:0] starve_cnt;
  logic             sat;
  assign sat   = starve_cnt == CNT_W'(STARVE_LIMIT);
  assign pick1 = bus.m1_req & (~bus.m0_req | sat);
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_cnt <= '0;
    else if (state == IDLE) starve_cnt <= (~bus.m1_req | pick1) ? '0 : sat ? starve_cnt : starve_cnt + 1'b1;
`endif
  assign bus.m0_gnt    = (state == IDLE) & any_req & ~pick1;
  assign bus.m1_gnt    = (state == IDLE) & pick1;
  assign bus.m0_rvalid = (state == RESP) & ~sel;
  assign bus.m1_rvalid = (state == RESP) & sel;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;
  // mem_wen doubles as the read/write flag of the command in ISSUE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      sel           <= 1'b1;
      bus.mem_wen   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      state         <= ISSUE;
      sel           <= pick1;
      bus.mem_wen   <= pick1 ? bus.m1_we : bus.m0_we;
      bus.mem_addr  <= pick1 ? bus.m1_addr : bus.m0_addr;
      bus.mem_wdata <= pick1 ? bus.m1_wdata : bus.m0_wdata;
    end else begin
      state       <= (state == ISSUE && !bus.mem_wen) ? RESP : IDLE;
      bus.mem_wen <= 1'b0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst;
  logic preload;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:255];
  logic [31:0] shadow [0:255];
  int streak;
  bit last_win;

  mem_arbiter_if #(.WORD_LEN(32)) bus ();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (bus.mem_wen) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // winner of a grant cycle given who is requesting (1 = M1)
  function automatic bit predict(input bit r0, input bit r1);
`ifdef MEM_ARB_RR_EN
    return (r0 && r1) ? !last_win : r1;
`else
    return r1 && (!r0 || streak >= LIMIT);
`endif
  endfunction

  function automatic void learn(input bit r1, input bit w);
    last_win = w;
    streak = (!r1 || w) ? 0 : (streak < LIMIT ? streak + 1 : streak);
  endfunction

  function automatic void model_reset();
    streak = 0;
    last_win = 1'b1;
  endfunction

  // starts and ends on a falling edge with the arbiter idle
  task automatic round(input bit r0, input bit r1, input bit we0, input bit we1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input bit poke);
    bit w, we;
    logic [31:0] a, d;
    bus.m0_req = r0; bus.m0_we = we0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = we1; bus.m1_addr = a1; bus.m1_wdata = d1;
    #1;
    w = predict(r0, r1);
    chk("gnt0", {31'b0, bus.m0_gnt}, {31'b0, !w});
    chk("gnt1", {31'b0, bus.m1_gnt}, {31'b0, w});
    learn(r1, w);
    a = w ? a1 : a0; d = w ? d1 : d0; we = w ? we1 : we0;
    @(negedge clk);
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    chk("issue_addr", bus.mem_addr, a);
    chk("issue_wen", {31'b0, bus.mem_wen}, {31'b0, we});
    chk("issue_gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
    if (we) begin
      chk("issue_wdata", bus.mem_wdata, d);
      shadow[a[9:2]] = d;
      @(negedge clk);
      chk("wen_pulse", {31'b0, bus.mem_wen}, 32'd0);
      chk("wr_no_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    end else begin
      @(negedge clk);
      chk("rvalid", {31'b0, w ? bus.m1_rvalid : bus.m0_rvalid}, 32'd1);
      chk("rdata", w ? bus.m1_rdata : bus.m0_rdata, shadow[a[9:2]]);
      chk("other_rvalid", {31'b0, w ? bus.m0_rvalid : bus.m1_rvalid}, 32'd0);
      chk("other_rdata", w ? bus.m0_rdata : bus.m1_rdata, 32'd0);
      if (poke) begin
        bus.m1_req = 1'b1;
        #1 chk("poke_gnt_resp", {31'b0, bus.m1_gnt}, 32'd0);
        #3 bus.m1_req = 1'b0;
      end
      @(negedge clk);
      chk("rvalid_once", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
      if (poke) begin
        chk("poke_gnt_idle", {31'b0, bus.m1_gnt}, 32'd0);
        chk("poke_addr", bus.mem_addr, a);
        @(negedge clk);
        chk("poke_no_access", {31'b0, bus.mem_wen}, 32'd0);
        chk("poke_addr_hold", bus.mem_addr, a);
      end
    end
  endtask

  initial begin
    int r;
    bit exp1;
    logic [31:0] ra0, ra1;
    rst = 1'b1; preload = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    @(negedge clk);
    preload = 1'b0;
    chk("rst_wen", {31'b0, bus.mem_wen}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
    chk("rst_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    // M0 read of a known word, then M1 write/read-back
    round(0, 1, 0, 1, 0, 32'h10, 0, 32'hDEADBEEF, 0);
    round(1, 0, 0, 0, 32'h10, 0, 0, 0, 0);
    round(0, 1, 0, 1, 0, 32'h20, 0, 32'h12345678, 0);
    round(0, 1, 0, 0, 0, 32'h20, 0, 0, 0);
    // M1 request withdrawn during an M0 read response
    round(1, 0, 0, 0, 32'h2C, 0, 0, 0, 1);
    // reset during the ISSUE cycle of a write
    round(1, 0, 1, 0, 32'h30, 0, 32'hA5A5A5A5, 0, 0);
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h30; bus.m0_wdata = 32'h11111111;
    #1 chk("rstw_gnt", {31'b0, bus.m0_gnt}, 32'd1);
    @(negedge clk);
    bus.m0_req = 0;
    chk("rstw_issue_wen", {31'b0, bus.mem_wen}, 32'd1);
    #1 rst = 1'b1;
    #1 chk("rstw_wen_async", {31'b0, bus.mem_wen}, 32'd0);
    @(negedge clk);
    chk("rstw_word_kept", mem[12], 32'hA5A5A5A5);
    chk("rstw_no_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rstw_idle_rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    round(1, 0, 0, 0, 32'h30, 0, 0, 0, 0);
    // randomized mixed traffic
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(1, 3);
      ra0 = $urandom & 32'h3FF;
      ra1 = $urandom & 32'h3FF;
      round(r[0], r[1], 1'($urandom), 1'($urandom), ra0, ra1, $urandom, $urandom, 0);
    end
    // both requesters held continuously with writes
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h100;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h104;
    for (int k = 0; k < 10; k++) begin
      bus.m0_wdata = 32'hC0DE0000 | k;
      bus.m1_wdata = 32'hFEED0000 | k;
      #1;
`ifdef MEM_ARB_RR_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = (k % (LIMIT + 1)) == LIMIT;
`endif
      chk("order", {30'b0, bus.m1_gnt, bus.m0_gnt}, exp1 ? 32'd2 : 32'd1);
      learn(1'b1, exp1);
      shadow[exp1 ? 65 : 64] = exp1 ? bus.m1_wdata : bus.m0_wdata;
      @(negedge clk);
      chk("order_wen", {31'b0, bus.mem_wen}, 32'd1);
      @(negedge clk);
    end
    bus.m0_req = 0; bus.m1_req = 0;
    round(1, 0, 0, 0, 32'h100, 0, 0, 0, 0);
    round(1, 0, 0, 0, 32'h104, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
